// File: rtl/malu_pkg.sv
// malu_pkg: shared types and helpers for the iterative M-extension unit.
//   malu_op_e    - RISC-V funct3 encodings of the eight M-extension ops
//   malu_state_e - control states of malu_iter
//   is_div / is_rem / is_signed_x / is_signed_y - op classification helpers
package malu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } malu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } malu_state_e;

  // Divide and remainder ops use the iterative divider.
  function automatic logic is_div(input malu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic is_rem(input malu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as two's complement.
  function automatic logic is_signed_x(input malu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as two's complement.
  function automatic logic is_signed_y(input malu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/malu_iter_if.sv
// malu_iter_if: request/response bundle of malu_iter.
//   Request : i_valid, i_op (funct3), i_x, i_y, i_tag, i_kill  -> unit
//             o_ready                                           <- unit
//   Response: o_valid, o_res, o_tag, o_busy                     <- unit
//             i_ready                                           -> unit
// The 'slave' modport is the unit side; 'master' is the issuing side.
interface malu_iter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);

  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic [XLEN-1:0]  i_x;
  logic [XLEN-1:0]  i_y;
  logic [TAG_W-1:0] i_tag;
  logic             i_kill;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_res;
  logic [TAG_W-1:0] o_tag;
  logic             o_busy;

  modport master (
    output i_valid, i_op, i_x, i_y, i_tag, i_kill, i_ready,
    input  o_ready, o_valid, o_res, o_tag, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_x, i_y, i_tag, i_kill, i_ready,
    output o_ready, o_valid, o_res, o_tag, o_busy
  );

endinterface

// File: rtl/malu_iter_div.sv
// div_restoring: unsigned XLEN-bit restoring radix-2 divider core.
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_start                 - load dividend/divisor, clear partial remainder
//   i_en                    - perform one iteration this cycle
//   i_dividend, i_divisor   - unsigned operands sampled on i_start
//   o_done                  - the iteration performed this cycle is the last
//   o_quot, o_rem           - quotient/remainder, valid after the last iteration
// Divide by zero naturally yields quotient all ones and remainder = dividend.
module div_restoring #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  // q_q starts as the dividend and shifts left; quotient bits enter at the LSB
  // while dividend bits leave at the MSB into the partial remainder.
  logic [XLEN-1:0]  q_q;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    r_shift;
  logic [XLEN:0]    diff;

  always_comb begin
    r_shift = {r_q, q_q[XLEN-1]};
    diff    = r_shift - {1'b0, d_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (i_start) begin
      q_q   <= i_dividend;
      r_q   <= '0;
      d_q   <= i_divisor;
      cnt_q <= '0;
    end else if (i_en) begin
      // diff[XLEN] set means the trial subtraction went negative: restore.
      r_q   <= diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
      q_q   <= {q_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_done = i_en && (cnt_q == '1);
  assign o_quot = q_q;
  assign o_rem  = r_q;

endmodule

// File: rtl/malu_iter.sv
// malu_iter: multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with a pass-through destination tag.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - request (i_valid/o_ready, i_op, i_x, i_y, i_tag, i_kill)
//                    and response (o_valid/i_ready, o_res, o_tag, o_busy)
// Multiplies take one compute cycle; divides run XLEN iterations of the
// restoring core followed by a sign-fix cycle. o_ready depends on state only.
// Build option MALU_DIV_EARLY_OUT_EN: divides by zero, signed overflow and
// divisor magnitude > dividend magnitude skip the iterations and go straight
// to the sign-fix cycle. Results are identical either way.
module malu_iter
  import malu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  malu_iter_if.slave  bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  malu_state_e      state_q, state_d;
  malu_op_e         op_q;
  malu_op_e         in_op;
  logic [XLEN-1:0]  x_q, y_q;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q;
  logic             accept;

  logic [XLEN-1:0]  in_mag_x, in_mag_y;
  logic             div_done;
  logic [XLEN-1:0]  div_quot, div_rem;

  logic [2*XLEN-1:0] ext_x, ext_y, prod;
  logic [XLEN-1:0]   mul_res;

  logic              sx, sy, ovf;
  logic [XLEN-1:0]   q_base, r_base;
  logic [XLEN-1:0]   quot_fin, rem_fin, div_res;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  assign in_op    = malu_op_e'(bus.i_op);
  // A kill in IDLE has nothing to abort but still blocks a same-cycle accept.
  assign accept   = (state_q == ST_IDLE) && bus.i_valid && !bus.i_kill;
  assign in_mag_x = mag(bus.i_x, is_signed_x(in_op));
  assign in_mag_y = mag(bus.i_y, is_signed_y(in_op));

`ifdef MALU_DIV_EARLY_OUT_EN
  logic in_ovf, early_in, early_q;

  assign in_ovf   = is_signed_y(in_op) && (bus.i_x == MIN_NEG) && (bus.i_y == '1);
  assign early_in = (bus.i_y == '0) || in_ovf || (in_mag_y > in_mag_x);
`endif

  // The core is loaded on the accept edge so the first iteration lands on
  // the following edge, keeping the result at accept + XLEN + 1.
  div_restoring #(
    .XLEN (XLEN)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (accept && is_div(in_op)),
    .i_en       (state_q == ST_DIV),
    .i_dividend (in_mag_x),
    .i_divisor  (in_mag_y),
    .o_done     (div_done),
    .o_quot     (div_quot),
    .o_rem      (div_rem)
  );

  // Multiply: extending both operands to 2*XLEN makes one unsigned product
  // correct for every signedness combination.
  assign ext_x   = {{XLEN{is_signed_x(op_q) & x_q[XLEN-1]}}, x_q};
  assign ext_y   = {{XLEN{is_signed_y(op_q) & y_q[XLEN-1]}}, y_q};
  assign prod    = ext_x * ext_y;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divide sign fix-up.
  assign sx  = is_signed_x(op_q) & x_q[XLEN-1];
  assign sy  = is_signed_y(op_q) & y_q[XLEN-1];
  assign ovf = is_signed_y(op_q) && (x_q == MIN_NEG) && (y_q == '1);

`ifdef MALU_DIV_EARLY_OUT_EN
  // Early-out divides never ran the core; the only non-forced case left is
  // |y| > |x|, whose unsigned result is quotient 0, remainder |x|.
  assign q_base = early_q ? '0 : div_quot;
  assign r_base = early_q ? mag(x_q, is_signed_x(op_q)) : div_rem;
`else
  assign q_base = div_quot;
  assign r_base = div_rem;
`endif

  always_comb begin
    quot_fin = (sx ^ sy) ? (~q_base + 1'b1) : q_base;
    rem_fin  = sx ? (~r_base + 1'b1) : r_base;
    if (y_q == '0) begin
      quot_fin = '1;
      rem_fin  = x_q;
    end else if (ovf) begin
      quot_fin = x_q;
      rem_fin  = '0;
    end
  end

  assign div_res = is_rem(op_q) ? rem_fin : quot_fin;

  // Next state and result register input.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div(in_op)) begin
`ifdef MALU_DIV_EARLY_OUT_EN
            state_d = early_in ? ST_FIX : ST_DIV;
`else
            state_d = ST_DIV;
`endif
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        res_d   = mul_res;
        state_d = ST_DONE;
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d   = div_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_kill && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      x_q     <= '0;
      y_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
`ifdef MALU_DIV_EARLY_OUT_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        op_q  <= in_op;
        x_q   <= bus.i_x;
        y_q   <= bus.i_y;
        tag_q <= bus.i_tag;
`ifdef MALU_DIV_EARLY_OUT_EN
        early_q <= early_in;
`endif
      end
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_res   = res_q;
  assign bus.o_tag   = tag_q;

endmodule

// File: doc/malu_iter.md
# malu_iter

Multi-cycle RISC-V M-extension arithmetic unit with valid/ready handshakes, parametrised in operand width. Multiplies complete in a single compute cycle. Divides and remainders use an iterative radix-2 divider, so a slow divide no longer sets the execute-stage clock. The unit sits in the execute stage beside the integer ALU and stalls issue through `o_ready`. It carries a destination tag and can be killed on pipeline flush.

## Interface
- `XLEN`, 32, operand/result width; legal values are 32 and 64.
- `TAG_W`, 5, width of the pass-through tag (destination register index).

- `i_clk` in 1 — clock; every register is rising-edge triggered.
- `i_rst_n` in 1 — asynchronous active-low reset.
- `i_valid` in 1 — request valid.
- `o_ready` out 1 — unit can accept a request.
- `i_op` in 3 — funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_x` in XLEN — rs1 operand.
- `i_y` in XLEN — rs2 operand.
- `i_tag` in TAG_W — request tag.
- `i_kill` in 1 — synchronous abort of the in-flight operation.
- `o_valid` out 1 — result valid.
- `i_ready` in 1 — consumer accepts the result.
- `o_res` out XLEN — result.
- `o_tag` out TAG_W — tag of the result.
- `o_busy` out 1 — state is not IDLE.

## Operation
- **States:** IDLE, MUL, DIV, FIX, DONE.
- **IDLE:**
  - `o_ready` is 1 only in IDLE.
  - Accept occurs when `i_valid && o_ready`: latch op, operands and tag.
  - MUL-class ops go to MUL; DIV/REM-class ops go to DIV.
- **MUL:**
  - Form a 2·XLEN product.
  - Operand extension: MUL/MULH use signed×signed; MULHSU uses signed×unsigned; MULHU uses unsigned×unsigned.
  - MUL returns bits [XLEN-1:0]; the other three return bits [2·XLEN-1:XLEN].
  - Register the result and go to DONE.
- **DIV:**
  - For signed ops, operands are converted to magnitudes; unsigned ops are used as-is.
  - Restoring radix-2 divide, one quotient bit per cycle, XLEN iterations, counted by a $clog2(XLEN)-bit counter.
  - Then go to FIX.
- **FIX:** apply signs.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Divide by zero: quotient is all ones; remainder equals `i_x`. These values are forced regardless of sign.
  - Signed overflow (x = −2^(XLEN−1), y = −1): quotient equals x; remainder is 0.
  - Register the result and go to DONE.
- **DONE:**
  - `o_valid` = 1; `o_res` and `o_tag` are held stable until `i_ready`.
  - On `o_valid && i_ready`, go to IDLE.
- **Kill:** `i_kill` in any non-IDLE state returns to IDLE at the next edge. No result is produced and `o_valid` drops. `i_kill` in IDLE is ignored, and a simultaneous accept is suppressed.
- **Reset:**
  - Asynchronous reset from any state, including mid-divide, forces IDLE.
  - Output reset values: `o_valid` 0, `o_ready` 1, `o_busy` 0, `o_res` 0, `o_tag` 0.

## Timing
- Accept at edge t0.
- MUL: result registered at t0+1; `o_valid` is high in the cycle after t0+1.
- DIV/REM: XLEN iteration edges plus the FIX edge; result registered at t0+XLEN+1. For XLEN=32 that is t0+33.
- When `i_ready` is held high, `o_valid` lasts 1 cycle. IDLE is re-entered at the next edge, so the minimum issue interval is latency+1.
- No combinational path from `i_valid`, `i_x`, `i_y` or `i_op` to any output. `o_ready` depends on state only.

## Configuration
- **`MALU_DIV_EARLY_OUT_EN`** defined:
  - From IDLE, a divide/remainder whose divisor is 0 or which is signed overflow goes directly to FIX, skipping DIV. Result is registered at t0+1.
  - A divisor greater than the dividend (unsigned magnitudes) also goes to FIX, with quotient 0 and remainder = magnitude of the dividend.
- **Undefined:** every divide/remainder takes the full XLEN+1 cycles.
- Results are bit-identical in both builds; only latency differs.

## Structure
- **Package `malu_pkg`:**
  - `malu_op_e` with the eight funct3 encodings.
  - `malu_state_e`.
  - Helper functions `is_div(op)` and `is_signed_x(op)` / `is_signed_y(op)`.
- **Sub-module `div_restoring`:** unsigned XLEN-bit restoring divider core.
  - Start, iteration-done and quotient/remainder ports.
  - Sign handling and the FIX state stay in `malu_iter`.

## Test plan
- MUL x=0xFFFFFFFF, y=0xFFFFFFFF → `o_res` 0x00000001 at t0+1. The same operands return MULH 0x00000000, MULHSU 0xFFFFFFFF and MULHU 0xFFFFFFFE.
- DIV x=−7, y=2 → quotient 0xFFFFFFFD (−3), result at t0+33. REM with the same operands → 0xFFFFFFFF (−1). DIVU 100/7 → 14; REMU → 2.
- DIV and REM with y=0, x=0x80000005 → DIV 0xFFFFFFFF, REM 0x80000005. DIV x=0x80000000, y=0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Hold `i_ready`=0 for 5 cycles after `o_valid` rises → `o_res`, `o_tag` and `o_valid` stay stable and `o_ready` stays 0. Then set `i_ready`=1 → IDLE the next cycle.
- Assert `i_kill` at DIV iteration 10 → `o_valid` never rises and `o_ready`=1 next cycle. Pulse `i_rst_n` low mid-divide in a separate run → reset values appear immediately.
- With `MALU_DIV_EARLY_OUT_EN`: DIVU 3/10 → 0 and REMU 3/10 → 3, both at t0+1. DIV by 0 at t0+1. Rerun the same tests with the macro undefined → same values, at t0+33.
